// File: rtl/filter_pkg.sv
// Shared constants for the filter MAC datapath: sequencer state encoding,
// term-mux select codes and coefficient indices.
package filter_pkg;

  localparam int DATA_W = 25;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_MAC_F0 = 3'd2;
  localparam logic [2:0] ST_MAC_F1 = 3'd3;
  localparam logic [2:0] ST_MAC_F2 = 3'd4;
  localparam logic [2:0] ST_MAC_Y1 = 3'd5;
  localparam logic [2:0] ST_MAC_Y2 = 3'd6;
  localparam logic [2:0] ST_WRITE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_MAC_F0 = ST_MAC_F0,
    S_MAC_F1 = ST_MAC_F1,
    S_MAC_F2 = ST_MAC_F2,
    S_MAC_Y1 = ST_MAC_Y1,
    S_MAC_Y2 = ST_MAC_Y2,
    S_WRITE  = ST_WRITE
  } state_e;

  // Select codes line up with the term mux inputs: zero, then newest to oldest.
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_T0   = 2'b01;
  localparam logic [1:0] SEL_T1   = 2'b10;
  localparam logic [1:0] SEL_T2   = 2'b11;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

endpackage

// File: rtl/filter_mac_seq.sv
// Sequencer for the shared MAC datapath: one pass per accepted sample tick,
// driving term/coefficient selects, accumulator control, delay-line shifts and output load.
module filter_mac_seq
  import filter_pkg::*;
#(
  parameter bit FEEDBACK = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sample_tick,
  input  logic             clr_ovr,
  output logic [1:0]       sel_fk,
  output logic [1:0]       sel_yk,
  output logic [2:0]       sel_coef,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             shift_x,
  output logic             shift_y,
  output logic             out_load,
  output logic             done,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] sample_count
);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  // Next state plus Moore decode; every output depends only on state_q.
  always_comb begin
    state_d  = state_q;
    sel_fk   = SEL_ZERO;
    sel_yk   = SEL_ZERO;
    sel_coef = COEF_B0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    shift_x  = 1'b0;
    shift_y  = 1'b0;
    out_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample_tick && en) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_x = 1'b1;
        acc_clr = 1'b1;
        state_d = S_MAC_F0;
      end
      S_MAC_F0: begin
        sel_fk   = SEL_T0;
        sel_coef = COEF_B0;
        acc_en   = 1'b1;
        state_d  = S_MAC_F1;
      end
      S_MAC_F1: begin
        sel_fk   = SEL_T1;
        sel_coef = COEF_B1;
        acc_en   = 1'b1;
        state_d  = S_MAC_F2;
      end
      S_MAC_F2: begin
        sel_fk   = SEL_T2;
        sel_coef = COEF_B2;
        acc_en   = 1'b1;
        state_d  = FEEDBACK ? S_MAC_Y1 : S_WRITE;
      end
      S_MAC_Y1: begin
        sel_yk   = SEL_T0;
        sel_coef = COEF_A1;
        acc_en   = 1'b1;
        state_d  = S_MAC_Y2;
      end
      S_MAC_Y2: begin
        sel_yk   = SEL_T1;
        sel_coef = COEF_A2;
        acc_en   = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        out_load = 1'b1;
        shift_y  = FEEDBACK;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A tick while busy is dropped and flagged; setting beats clearing.
  always_comb begin
    done_d    = out_load;
    count_d   = out_load ? count_q + CNT_W'(1) : count_q;
    overrun_d = overrun_q;
    if (clr_ovr) overrun_d = 1'b0;
    if (sample_tick && (state_q != S_IDLE)) overrun_d = 1'b1;
  end

  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_filter_mac_seq.sv
// Directed bench for filter_mac_seq: an IIR instance (16-bit counter) and a FIR
// instance (4-bit counter, so counter wrap is reachable) share one stimulus.
module tb_filter_mac_seq;

  logic clk;
  logic reset;
  logic en;
  logic sample_tick;
  logic clr_ovr;

  logic [1:0]  i_sel_fk, i_sel_yk, f_sel_fk, f_sel_yk;
  logic [2:0]  i_sel_coef, f_sel_coef;
  logic        i_acc_clr, i_acc_en, i_shift_x, i_shift_y, i_out_load, i_done, i_busy, i_ovr;
  logic        f_acc_clr, f_acc_en, f_shift_x, f_shift_y, f_out_load, f_done, f_busy, f_ovr;
  logic [15:0] i_cnt;
  logic [3:0]  f_cnt;

  int total;
  int bad;

  logic [15:0] exp_q[$];

  filter_mac_seq #(.FEEDBACK(1'b1), .CNT_W(16)) dut_iir (
    .clk(clk), .reset(reset), .en(en), .sample_tick(sample_tick), .clr_ovr(clr_ovr),
    .sel_fk(i_sel_fk), .sel_yk(i_sel_yk), .sel_coef(i_sel_coef),
    .acc_clr(i_acc_clr), .acc_en(i_acc_en), .shift_x(i_shift_x), .shift_y(i_shift_y),
    .out_load(i_out_load), .done(i_done), .busy(i_busy), .overrun(i_ovr),
    .sample_count(i_cnt)
  );

  filter_mac_seq #(.FEEDBACK(1'b0), .CNT_W(4)) dut_fir (
    .clk(clk), .reset(reset), .en(en), .sample_tick(sample_tick), .clr_ovr(clr_ovr),
    .sel_fk(f_sel_fk), .sel_yk(f_sel_yk), .sel_coef(f_sel_coef),
    .acc_clr(f_acc_clr), .acc_en(f_acc_en), .shift_x(f_shift_x), .shift_y(f_shift_y),
    .out_load(f_out_load), .done(f_done), .busy(f_busy), .overrun(f_ovr),
    .sample_count(f_cnt)
  );

  // {sel_fk, sel_yk, sel_coef, acc_clr, acc_en, shift_x, shift_y, out_load, done, busy}
  logic [13:0] obs_iir, obs_fir;
  assign obs_iir = {i_sel_fk, i_sel_yk, i_sel_coef, i_acc_clr, i_acc_en, i_shift_x,
                    i_shift_y, i_out_load, i_done, i_busy};
  assign obs_fir = {f_sel_fk, f_sel_yk, f_sel_coef, f_acc_clr, f_acc_en, f_shift_x,
                    f_shift_y, f_out_load, f_done, f_busy};

  // Expected per-cycle outputs; entry c is cycle k+1+c after the tick is sampled at edge k.
  logic [13:0] iir_tab [8] = '{
    14'b00_00_000_1_0_1_0_0_0_1,  // LOAD
    14'b01_00_000_0_1_0_0_0_0_1,  // MAC_F0
    14'b10_00_001_0_1_0_0_0_0_1,  // MAC_F1
    14'b11_00_010_0_1_0_0_0_0_1,  // MAC_F2
    14'b00_01_011_0_1_0_0_0_0_1,  // MAC_Y1
    14'b00_10_100_0_1_0_0_0_0_1,  // MAC_Y2
    14'b00_00_000_0_0_0_1_1_0_1,  // WRITE
    14'b00_00_000_0_0_0_0_0_1_0   // IDLE, done
  };
  logic [13:0] fir_tab [8] = '{
    14'b00_00_000_1_0_1_0_0_0_1,
    14'b01_00_000_0_1_0_0_0_0_1,
    14'b10_00_001_0_1_0_0_0_0_1,
    14'b11_00_010_0_1_0_0_0_0_1,
    14'b00_00_000_0_0_0_0_1_0_1,  // WRITE, no shift_y
    14'b00_00_000_0_0_0_0_0_1_0,  // IDLE, done
    14'b00_00_000_0_0_0_0_0_0_0,
    14'b00_00_000_0_0_0_0_0_0_0
  };

  logic [13:0] cap_iir [8];
  logic [13:0] cap_fir [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick sampled at the next rising edge, then capture eight cycles at negedges.
  // Extra stimulus is applied at the negedge of cycle c for the edge that ends it.
  task automatic tick_and_capture(input int tick_at, input int clr_at, input int en_off_at);
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cap_iir[c-1] = obs_iir;
      cap_fir[c-1] = obs_fir;
      sample_tick  = (c == tick_at);
      clr_ovr      = (c == clr_at);
      if (c == en_off_at) en = 1'b0;
    end
    sample_tick = 1'b0;
    clr_ovr     = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (obs_iir !== 14'd0) begin bad++; $display("FAIL reset_outs_iir got=%b exp=0", obs_iir); end
    total++; if (obs_fir !== 14'd0) begin bad++; $display("FAIL reset_outs_fir got=%b exp=0", obs_fir); end
    total++; if ({i_ovr, f_ovr} !== 2'b00) begin bad++; $display("FAIL reset_ovr got=%b%b exp=00", i_ovr, f_ovr); end
    total++; if (i_cnt !== 16'd0 || f_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", i_cnt, f_cnt); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_pass();
    tick_and_capture(0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      total++; if (cap_iir[c] !== iir_tab[c]) begin bad++; $display("FAIL iir_cycle%0d got=%b exp=%b", c + 1, cap_iir[c], iir_tab[c]); end
      total++; if (cap_fir[c] !== fir_tab[c]) begin bad++; $display("FAIL fir_cycle%0d got=%b exp=%b", c + 1, cap_fir[c], fir_tab[c]); end
    end
    total++; if (i_cnt !== 16'd1 || f_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d/%0d exp=1/1", i_cnt, f_cnt); end
    total++; if ({i_ovr, f_ovr} !== 2'b00) begin bad++; $display("FAIL single_ovr got=%b%b exp=00", i_ovr, f_ovr); end
  endtask

  task automatic test_overrun();
    tick_and_capture(3, 0, 0);
    total++; if ({i_ovr, f_ovr} !== 2'b11) begin bad++; $display("FAIL ovr_set got=%b%b exp=11", i_ovr, f_ovr); end
    total++; if (i_cnt !== 16'd2 || f_cnt !== 4'd2) begin bad++; $display("FAIL ovr_cnt got=%0d/%0d exp=2/2", i_cnt, f_cnt); end
    total++; if (cap_iir[7] !== iir_tab[7]) begin bad++; $display("FAIL ovr_done got=%b exp=%b", cap_iir[7], iir_tab[7]); end
    // Tick and clear in the same busy cycle: the set wins.
    tick_and_capture(3, 3, 0);
    total++; if ({i_ovr, f_ovr} !== 2'b11) begin bad++; $display("FAIL ovr_set_wins got=%b%b exp=11", i_ovr, f_ovr); end
    total++; if (i_cnt !== 16'd3 || f_cnt !== 4'd3) begin bad++; $display("FAIL ovr_cnt2 got=%0d/%0d exp=3/3", i_cnt, f_cnt); end
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    total++; if ({i_ovr, f_ovr} !== 2'b00) begin bad++; $display("FAIL ovr_clear got=%b%b exp=00", i_ovr, f_ovr); end
  endtask

  task automatic test_enable();
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      total++; if ({i_busy, f_busy} !== 2'b00) begin bad++; $display("FAIL en_low_busy%0d got=%b%b exp=00", n, i_busy, f_busy); end
    end
    total++; if ({i_ovr, f_ovr} !== 2'b00 || i_cnt !== 16'd3) begin bad++; $display("FAIL en_low_ovr got=%b%b cnt=%0d exp=00 cnt=3", i_ovr, f_ovr, i_cnt); end
    en = 1'b1;
    tick_and_capture(0, 0, 2);
    total++; if (cap_iir[6] !== iir_tab[6] || cap_iir[7] !== iir_tab[7]) begin bad++; $display("FAIL en_drop_iir got=%b/%b exp=%b/%b", cap_iir[6], cap_iir[7], iir_tab[6], iir_tab[7]); end
    total++; if (cap_fir[5] !== fir_tab[5]) begin bad++; $display("FAIL en_drop_fir got=%b exp=%b", cap_fir[5], fir_tab[5]); end
    total++; if (i_cnt !== 16'd4) begin bad++; $display("FAIL en_drop_cnt got=%0d exp=4", i_cnt); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_pass();
    int seen_done;
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (obs_iir !== 14'd0 || obs_fir !== 14'd0) begin bad++; $display("FAIL midreset_outs got=%b/%b exp=0/0", obs_iir, obs_fir); end
    total++; if (i_cnt !== 16'd0 || f_cnt !== 4'd0 || i_ovr !== 1'b0) begin bad++; $display("FAIL midreset_regs got=%0d/%0d/%b exp=0/0/0", i_cnt, f_cnt, i_ovr); end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_done || f_done || i_out_load || f_out_load || i_busy) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL midreset_quiet got=%0d exp=0", seen_done); end
    tick_and_capture(0, 0, 0);
    total++; if (cap_iir[0] !== iir_tab[0] || cap_iir[7] !== iir_tab[7]) begin bad++; $display("FAIL midreset_restart got=%b/%b exp=%b/%b", cap_iir[0], cap_iir[7], iir_tab[0], iir_tab[7]); end
    total++; if (i_cnt !== 16'd1) begin bad++; $display("FAIL midreset_cnt got=%0d exp=1", i_cnt); end
  endtask

  // 17 passes at the IIR minimum spacing; the 4-bit FIR counter wraps to 1.
  task automatic test_back_to_back();
    logic [15:0] exp_cnt;
    logic [15:0] exp_v;
    apply_reset();
    exp_cnt = 16'd0;
    for (int p = 0; p <= 17; p++) begin
      @(negedge clk);
      if (p > 0) begin
        exp_v = exp_q.pop_front();
        total++; if (i_done !== 1'b1 || i_cnt !== exp_v || {12'd0, f_cnt} !== (exp_v & 16'hF)) begin
          bad++; $display("FAIL b2b_pass%0d done=%b cnt=%0d/%0d exp=1 %0d/%0d", p, i_done, i_cnt, f_cnt, exp_v, exp_v & 16'hF);
        end
      end
      if (p == 17) break;
      sample_tick = 1'b1;
      exp_cnt = exp_cnt + 16'd1;
      exp_q.push_back(exp_cnt);
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (6) @(negedge clk);
    end
    total++; if (f_cnt !== 4'd1) begin bad++; $display("FAIL b2b_wrap got=%0d exp=1", f_cnt); end
    total++; if ({i_ovr, f_ovr} !== 2'b00) begin bad++; $display("FAIL b2b_ovr got=%b%b exp=00", i_ovr, f_ovr); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_queue got=%0d exp=0", exp_q.size()); end
  endtask

  // Ticks every 6 cycles: FIR keeps up; IIR accepts ticks 0,2,4 and flags overrun.
  task automatic test_fir_min_spacing();
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    total++; if (f_cnt !== 4'd5 || f_ovr !== 1'b0) begin bad++; $display("FIR spacing FAIL fir_min got cnt=%0d ovr=%b exp cnt=5 ovr=0", f_cnt, f_ovr); end
    total++; if (i_cnt !== 16'd3 || i_ovr !== 1'b1) begin bad++; $display("FAIL iir_at_6 got cnt=%0d ovr=%b exp cnt=3 ovr=1", i_cnt, i_ovr); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    en          = 1'b1;
    sample_tick = 1'b0;
    clr_ovr     = 1'b0;
    test_reset();
    test_single_pass();
    test_overrun();
    test_enable();
    test_reset_mid_pass();
    test_back_to_back();
    test_fir_min_spacing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
